dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 19 +
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_responder.sv | 102 ++++++++++
 tb/tb_dmem_responder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared states, defaults and address check for the data-memory responder
package dmem_responder_pkg;

    localparam int DEPTH_WORDS_DEFAULT = 64;
    localparam int WAIT_CYCLES_DEFAULT = 2;
    localparam int CNT_W               = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misaligned or beyond the end of the word array.
    function automatic logic addr_is_bad(input logic [31:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || (addr >= 32'(4 * depth_words));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - CPU request/response bus for the data-memory responder
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word RAM with byte-enabled write, reset clear, access and debug read ports
module dmem_array #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
    output logic [31:0]                    dbg_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata    = mem[addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder: accept, count down, access, one-cycle response
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    dmem_responder_if.slave                bus,
    input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
    output logic [31:0]                    dbg_data
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_we;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic [3:0]         lat_be;
    logic               resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;

    logic               access;
    logic               acc_err;
    logic               arr_we;
    logic [31:0]        arr_rdata;

    assign access  = (state == ST_BUSY) && (cnt == '0);
    assign acc_err = addr_is_bad(lat_addr, DEPTH_WORDS);
    assign arr_we  = access && lat_we && !acc_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .we       (arr_we),
        .be       (lat_be),
        .addr     (lat_addr[2 +: AW]),
        .wdata    (lat_wdata),
        .rdata    (arr_rdata),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            lat_we       <= 1'b0;
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
            lat_be       <= 4'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_we    <= bus.req_we;
                        lat_addr  <= bus.req_addr;
                        lat_wdata <= bus.req_wdata;
                        lat_be    <= bus.req_be;
                        cnt       <= CNT_W'(WAIT_CYCLES);
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // Stores and rejected accesses both answer with zero data.
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= acc_err;
                        resp_rdata_q <= (lat_we || acc_err) ? 32'h0 : arr_rdata;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    resp_err_q   <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder (WAIT_CYCLES 2 and 0)
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int WA    = 2;
    localparam int WB    = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rv = 1'b0;
    logic        rwe = 1'b0;
    logic [31:0] raddr = 32'h0;
    logic [31:0] rwdata = 32'h0;
    logic [3:0]  rbe = 4'h0;
    logic        sel = 1'b0;
    logic [5:0]  dbg_addr_a = 6'd0;
    logic [5:0]  dbg_addr_b = 6'd0;
    logic [31:0] dbg_data_a;
    logic [31:0] dbg_data_b;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [31:0] model [DEPTH];

    dmem_responder_if ia ();
    dmem_responder_if ib ();

    assign ia.req_valid = rv & ~sel;
    assign ib.req_valid = rv & sel;
    assign ia.req_we    = rwe;
    assign ib.req_we    = rwe;
    assign ia.req_addr  = raddr;
    assign ib.req_addr  = raddr;
    assign ia.req_wdata = rwdata;
    assign ib.req_wdata = rwdata;
    assign ia.req_be    = rbe;
    assign ib.req_be    = rbe;

    wire        s_ready  = sel ? ib.req_ready  : ia.req_ready;
    wire        s_rvalid = sel ? ib.resp_valid : ia.resp_valid;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA)) dut_a (
        .clk(clk), .reset(reset), .bus(ia), .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WB)) dut_b (
        .clk(clk), .reset(reset), .bus(ib), .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    // One request to dut_a; the bench model predicts the response.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        exp_t got;
        int   n;
        int   k;
        int   idx;
        logic bad;
        idx = int'(addr[7:2]);
        bad = (addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
        e.err   = bad;
        e.rdata = (we || bad) ? 32'h0 : model[idx];
        if (we && !bad) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        sb.push_back(e);
        @(negedge clk);
        dbg_addr_a = addr[7:2];
        rv = 1'b1; rwe = we; raddr = addr; rwdata = wdata; rbe = be;
        n = 0;
        while (!s_ready && n < 50) begin @(negedge clk); n++; end
        check({tag, "_accept_timeout"}, {31'b0, s_ready}, 32'd1);
        k = cyc + 1;
        @(negedge clk);
        rv = 1'b0; rwe = ~we; raddr = $urandom; rwdata = $urandom; rbe = 4'(~be);
        n = 0;
        while (!s_rvalid && n < 50) begin @(negedge clk); n++; end
        check({tag, "_resp_timeout"}, {31'b0, s_rvalid}, 32'd1);
        got = sb.pop_front();
        check({tag, "_rdata"}, ia.resp_rdata, got.rdata);
        check({tag, "_err"}, {31'b0, ia.resp_err}, {31'b0, got.err});
        check({tag, "_latency"}, 32'(cyc - k), 32'(WA + 1));
        if (we && !bad) check({tag, "_dbg_visible"}, dbg_data_a, model[idx]);
        @(negedge clk);
        check({tag, "_pulse_end"}, {ia.resp_rdata[30:0], ia.resp_valid | ia.resp_err}, 32'd0);
    endtask

    task automatic b2b(input string tag, input int w);
        int a0;
        int a1;
        int pulses;
        a0 = -1; a1 = -1; pulses = 0;
        @(negedge clk);
        rv = 1'b1; rwe = 1'b0; raddr = 32'h8; rbe = 4'h0;
        for (int n = 0; n < 40; n++) begin
            if (s_rvalid) pulses++;
            if (s_ready && rv) begin
                if (a0 < 0) a0 = cyc + 1;
                else a1 = cyc + 1;
            end
            @(negedge clk);
            if (a1 >= 0) rv = 1'b0;
        end
        check({tag, "_accept_gap"}, 32'(a1 - a0), 32'(w + 3));
        check({tag, "_pulses"}, 32'(pulses), 32'd2);
    endtask

    task automatic no_pulse(input string tag);
        int pulses;
        pulses = 0;
        repeat (8) begin
            if (ia.resp_valid) pulses++;
            @(negedge clk);
        end
        check({tag, "_no_pulse"}, 32'(pulses), 32'd0);
        dbg_addr_a = 6'd0;
        #1 check({tag, "_word0"}, dbg_data_a, 32'h0);
    endtask

    initial begin
        clear_model();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, ia.req_ready}, 32'd1);
        check("rst_resp", {ia.resp_rdata[30:0], ia.resp_valid | ia.resp_err}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dbg_addr_a = 6'(i);
            #1 check("rst_dbg_word", dbg_data_a, 32'h0);
        end

        do_req("st_8", 1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
        do_req("ld_8", 1'b0, 32'h8, 32'h0, 4'h0);
        dbg_addr_a = 6'd2;
        #1 check("word2_const", dbg_data_a, 32'hDEADBEEF);

        do_req("st_4_full", 1'b1, 32'h4, 32'hAAAAAAAA, 4'hF);
        do_req("st_4_be5", 1'b1, 32'h4, 32'h11223344, 4'h5);
        dbg_addr_a = 6'd1;
        #1 check("word1_merge", dbg_data_a, 32'hAA22AA44);
        do_req("ld_4", 1'b0, 32'h4, 32'h0, 4'h3);

        do_req("st_0", 1'b1, 32'h0, 32'h12345678, 4'hF);
        do_req("ld_mis", 1'b0, 32'h6, 32'h0, 4'hF);
        do_req("ld_oor", 1'b0, 32'h100, 32'h0, 4'hF);
        do_req("st_oor", 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF);
        do_req("st_mis", 1'b1, 32'h9, 32'hFFFFFFFF, 4'hF);
        dbg_addr_a = 6'd0;
        #1 check("word0_after_err", dbg_data_a, 32'h12345678);
        dbg_addr_a = 6'd2;
        #1 check("word2_after_err", dbg_data_a, 32'hDEADBEEF);

        do_req("st_be0", 1'b1, 32'h8, 32'h01020304, 4'h0);
        do_req("ld_top", 1'b0, 32'hFC, 32'h0, 4'h0);
        do_req("st_top", 1'b1, 32'hFC, 32'h5A5AC3C3, 4'hC);
        do_req("ld_top2", 1'b0, 32'hFC, 32'h0, 4'h1);

        // Reset one edge after accepting a store.
        @(negedge clk);
        rv = 1'b1; rwe = 1'b1; raddr = 32'h0; rwdata = 32'hCAFEF00D; rbe = 4'hF;
        @(negedge clk);
        rv = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        check("abort_ready", {31'b0, ia.req_ready}, 32'd1);
        no_pulse("abort");

        // Reset together with an accept.
        rv = 1'b1; rwe = 1'b1; raddr = 32'h0; rwdata = 32'h5A5A5A5A; rbe = 4'hF;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; rv = 1'b0;
        no_pulse("prio");

        b2b("b2b_w2", WA);
        sel = 1'b1;
        b2b("b2b_w0", WB);
        sel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
